// File: rtl/multdiv_pkg.sv
// Shared definitions for the MultDiv sequencers (divider and multiplier).
package multdiv_pkg;

  localparam int MD_WIDTH = 32;
  localparam int CNT_W    = $clog2(MD_WIDTH);
  localparam logic [MD_WIDTH-1:0] INT_MIN = {1'b1, {(MD_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/mag_comp_ge.sv
// Unsigned a >= b built from an MSB-first cascade of 2-bit EQ/GT slices.
module mag_comp_ge #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ge
);

  localparam int NSL = WIDTH / 2;

  logic [NSL:0] eq;
  logic [NSL:0] gt;

  assign eq[0] = 1'b1;
  assign gt[0] = 1'b0;

  for (genvar i = 0; i < NSL; i++) begin : g_slice
    logic [1:0] a2;
    logic [1:0] b2;
    assign a2        = a[WIDTH-1-2*i -: 2];
    assign b2        = b[WIDTH-1-2*i -: 2];
    // a higher slice that already decided GT wins; lower slices only matter while equal
    assign gt[i+1]   = gt[i] | (eq[i] & (a2 > b2));
    assign eq[i+1]   = eq[i] & (a2 == b2);
  end

  assign ge = gt[NSL] | eq[NSL];

endmodule

// File: rtl/div_seq.sv
// Multicycle signed restoring divider, one quotient bit per clock.
// Optional remainder output enabled by defining DIV_REMAINDER_EN.
module div_seq
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
`ifdef DIV_REMAINDER_EN
  output logic [WIDTH-1:0] data_remainder,
`endif
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = (WIDTH == MD_WIDTH) ? CNT_W : $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);

  seq_state_t state, state_next;

  logic [WIDTH-1:0] a_sh, b_mag, rem, quo;
  logic [CW-1:0]    cnt;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] rem_shift;
  logic             ge;
  logic             exc_start;

  // two's-complement negate also maps INT_MIN to unsigned 2^(WIDTH-1)
  assign exc_start = (data_operandB == '0) ||
                     ((data_operandA == MIN_VAL) && (data_operandB == '1));
  assign rem_shift = {rem[WIDTH-2:0], a_sh[WIDTH-1]};
  assign busy      = (state != IDLE);

  mag_comp_ge #(.WIDTH(WIDTH)) u_cmp (
    .a  (rem_shift),
    .b  (b_mag),
    .ge (ge)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ctrl_DIV) state_next = exc_start ? DONE : ITER;
      ITER:    if (cnt == CNT_LAST) state_next = FIXUP;
      FIXUP:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_sh           <= '0;
      b_mag          <= '0;
      rem            <= '0;
      quo            <= '0;
      cnt            <= '0;
      sign_a         <= 1'b0;
      sign_b         <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
`ifdef DIV_REMAINDER_EN
      data_remainder <= '0;
`endif
    end else begin
      data_resultRDY <= 1'b0;
      case (state)
        IDLE: begin
          if (ctrl_DIV) begin
            a_sh   <= data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
            b_mag  <= data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
            sign_a <= data_operandA[WIDTH-1];
            sign_b <= data_operandB[WIDTH-1];
            rem    <= '0;
            quo    <= '0;
            cnt    <= '0;
            if (exc_start) begin
              data_exception <= 1'b1;
              data_result    <= '0;
`ifdef DIV_REMAINDER_EN
              data_remainder <= '0;
`endif
            end else begin
              data_exception <= 1'b0;
            end
          end
        end
        ITER: begin
          a_sh <= {a_sh[WIDTH-2:0], 1'b0};
          rem  <= ge ? (rem_shift - b_mag) : rem_shift;
          quo  <= {quo[WIDTH-2:0], ge};
          if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
        end
        FIXUP: begin
          data_result <= (sign_a ^ sign_b) ? -quo : quo;
`ifdef DIV_REMAINDER_EN
          data_remainder <= sign_a ? -rem : rem;
`endif
        end
        DONE: data_resultRDY <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: vector table plus busy-restart and mid-operation reset sequences.
module tb_div_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_DIV;
  logic [31:0] data_operandA, data_operandB;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy;
`ifdef DIV_REMAINDER_EN
  logic [31:0] data_remainder;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  div_seq #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
`ifdef DIV_REMAINDER_EN
    .data_remainder (data_remainder),
`endif
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic        exc;
    logic [31:0] r;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Starts an operation and waits for the ready pulse. repulse/rst_at give the
  // edge number (relative to the start edge) for an extra start pulse or a reset.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input int repulse_at, input int rst_at,
                        output int lat, output logic busy_ok, output logic rdy_next);
    lat      = 0;
    busy_ok  = 1'b1;
    rdy_next = 1'b0;
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_DIV      = 1'b1;
    @(posedge clock);
    #1;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clock);
      if (n == repulse_at) begin
        data_operandA = 32'd9;
        data_operandB = 32'd3;
        ctrl_DIV      = 1'b1;
      end
      if (n == rst_at) reset = 1'b1;
      @(posedge clock);
      #1;
      ctrl_DIV = 1'b0;
      if (n == rst_at) begin
        reset = 1'b0;
        chk("rst_mid_result", data_result, 32'd0);
        chk("rst_mid_exc", {31'd0, data_exception}, 32'd0);
        chk("rst_mid_rdy", {31'd0, data_resultRDY}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
      end
      if (data_resultRDY) begin
        lat = n;
        if (busy) busy_ok = 1'b0;
        @(posedge clock);
        #1;
        rdy_next = data_resultRDY;
        break;
      end
      if (rst_at == 0 && !busy) busy_ok = 1'b0;
    end
  endtask

  initial begin
    int          lat;
    logic        bok, rnext;

    vecs[0]  = '{32'd100,      32'd7,          32'd14,         1'b0, 32'd2,          34};
    vecs[1]  = '{-32'sd100,    32'd7,          -32'sd14,       1'b0, -32'sd2,        34};
    vecs[2]  = '{32'd100,      -32'sd7,        -32'sd14,       1'b0, 32'd2,          34};
    vecs[3]  = '{-32'sd100,    -32'sd7,        32'd14,         1'b0, -32'sd2,        34};
    vecs[4]  = '{32'd7,        32'd0,          32'd0,          1'b1, 32'd0,          1};
    vecs[5]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd0,          1'b1, 32'd0,          1};
    vecs[6]  = '{32'd5,        32'd9,          32'd0,          1'b0, 32'd5,          34};
    vecs[7]  = '{32'h8000_0000, 32'd1,         32'h8000_0000,  1'b0, 32'd0,          34};
    vecs[8]  = '{32'h8000_0000, 32'h8000_0000, 32'd1,          1'b0, 32'd0,          34};
    vecs[9]  = '{32'h7FFF_FFFF, 32'h8000_0000, 32'd0,          1'b0, 32'h7FFF_FFFF,  34};
    vecs[10] = '{-32'sd5,      32'd9,          32'd0,          1'b0, -32'sd5,        34};
    vecs[11] = '{32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF,  1'b0, 32'd0,          34};
    vecs[12] = '{32'd1000,     32'd10,         32'd100,        1'b0, 32'd0,          34};

    reset         = 1'b1;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_result", data_result, 32'd0);
    chk("reset_exc", {31'd0, data_exception}, 32'd0);
    chk("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].a, vecs[i].b, 0, 0, lat, bok, rnext);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_result", i), data_result, vecs[i].q);
      chk($sformatf("v%0d_exc", i), {31'd0, data_exception}, {31'd0, vecs[i].exc});
      chk($sformatf("v%0d_busy", i), {31'd0, bok}, 32'd1);
      chk($sformatf("v%0d_rdy_pulse", i), {31'd0, rnext}, 32'd0);
`ifdef DIV_REMAINDER_EN
      chk($sformatf("v%0d_rem", i), data_remainder, vecs[i].r);
`endif
    end

    // start while busy must be ignored
    run_op(32'd100, 32'd7, 10, 0, lat, bok, rnext);
    chk("repulse_latency", lat, 34);
    chk("repulse_result", data_result, 32'd14);
    chk("repulse_busy", {31'd0, bok}, 32'd1);

    // reset mid-operation: no ready pulse ever arrives
    run_op(32'd100, 32'd7, 0, 20, lat, bok, rnext);
    chk("rst_no_rdy", lat, 0);
    run_op(32'd21, -32'sd3, 0, 0, lat, bok, rnext);
    chk("after_rst_latency", lat, 34);
    chk("after_rst_result", data_result, -32'sd7);
    chk("after_rst_exc", {31'd0, data_exception}, 32'd0);
`ifdef DIV_REMAINDER_EN
    chk("after_rst_rem", data_remainder, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
